// File: rtl/uram_arb_pkg.sv
// uram_arb_pkg: shared constants, CLEAR sequencer state type and read-latency helper
// for the UltraRAM port arbiter.
package uram_arb_pkg;

    localparam int URAM_AW    = 12;
    localparam int URAM_DW    = 72;
    localparam int URAM_DEPTH = 4096;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Read latency seen at the RAM boundary: one array stage plus optional output register.
    function automatic int rd_lat(input int oreg);
        return 1 + oreg;
    endfunction

endpackage

// File: rtl/uram_arb_rr_arb.sv
// rr_arb: one-hot round-robin arbiter. Search starts at ptr; next_ptr points one past
// the winner, or holds ptr when nothing is requested. With N == 1 the pointer stays 0.
module rr_arb #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan requesters starting at ptr; first active one wins.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = PW'(((int'(ptr) + k) % N + 1) % N);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uram_arb.sv
// uram_arb: shares one 4096x72 UltraRAM (1 write + 1 read port) between NREQ requesters
// with independent round-robin arbitration per port, a tagged read-response pipe and a
// zero-fill CLEAR sequencer.
// Optional feature: define URAM_ARB_FWD_EN to forward same-cycle write data to a read of
// the same address; otherwise the RAM's read-first behaviour is visible.
module uram_arb
    import uram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int OREG = 0,
    parameter int AW   = URAM_AW,
    parameter int DW   = URAM_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              ram_wen,
    output logic [AW-1:0]     ram_waddr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_ren,
    output logic [AW-1:0]     ram_raddr,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int            L         = rd_lat(OREG);
    localparam int            PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'((1 << AW) - 1);

    state_t          state_reg;
    logic [AW-1:0]   clr_cnt_reg;
    logic [PW-1:0]   wptr_reg, rptr_reg, wptr_next, rptr_next;
    logic [NREQ-1:0] wcand, rcand, wgnt, rgnt;
    logic            clearing;
    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [AW-1:0]   gnt_waddr, gnt_raddr;
    logic [DW-1:0]   gnt_wdata;
    logic            pipe_vld [L];
    logic [NREQ-1:0] pipe_id  [L];

    assign clearing = (state_reg == CLEAR);
    assign clr_busy = clearing;

    // CLEAR owns the write port, so requester writes are not even candidates then.
    assign wcand = clearing ? '0 : (req_valid & req_we);
    assign rcand = req_valid & ~req_we;

    rr_arb #(.N(NREQ), .PW(PW)) u_warb (
        .req      (wcand),
        .ptr      (wptr_reg),
        .gnt      (wgnt),
        .next_ptr (wptr_next)
    );

    rr_arb #(.N(NREQ), .PW(PW)) u_rarb (
        .req      (rcand),
        .ptr      (rptr_reg),
        .gnt      (rgnt),
        .next_ptr (rptr_next)
    );

    assign req_ready = wgnt | rgnt;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*AW +: AW];
        assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end

    // Steer the winning requester's address/data onto the RAM ports (zero when idle).
    always_comb begin
        gnt_waddr = '0;
        gnt_wdata = '0;
        gnt_raddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wgnt[i]) begin
                gnt_waddr = addr_arr[i];
                gnt_wdata = wdata_arr[i];
            end
            if (rgnt[i]) begin
                gnt_raddr = addr_arr[i];
            end
        end
    end

    assign ram_wen   = clearing | (|wgnt);
    assign ram_waddr = clearing ? clr_cnt_reg : gnt_waddr;
    assign ram_wdata = clearing ? '0 : gnt_wdata;
    assign ram_ren   = |rgnt;
    assign ram_raddr = gnt_raddr;

    // Round-robin pointers advance only when their port granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

    // CLEAR sequencer: one address per cycle from 0 to the last, then back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            clr_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_cnt_reg <= '0;
                    if (clr_start) begin
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    clr_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Response tag pipe, matched to the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_id[k]  <= '0;
            end
        end else begin
            pipe_vld[0] <= ram_ren;
            pipe_id[0]  <= rgnt;
            for (int k = 1; k < L; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
        end
    end

    assign rsp_valid = pipe_vld[L-1] ? pipe_id[L-1] : '0;

`ifdef URAM_ARB_FWD_EN
    logic          fwd_hit;
    logic          fwd_vld  [L];
    logic [DW-1:0] fwd_data [L];

    assign fwd_hit = ram_ren & ram_wen & (ram_raddr == ram_waddr);

    // Capture the colliding write data at grant and age it alongside the read tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                fwd_vld[k]  <= 1'b0;
                fwd_data[k] <= '0;
            end
        end else begin
            fwd_vld[0]  <= fwd_hit;
            fwd_data[0] <= ram_wdata;
            for (int k = 1; k < L; k++) begin
                fwd_vld[k]  <= fwd_vld[k-1];
                fwd_data[k] <= fwd_data[k-1];
            end
        end
    end

    assign rsp_data = fwd_vld[L-1] ? fwd_data[L-1] : ram_rdata;
`else
    assign rsp_data = ram_rdata;
`endif

endmodule
